soc_axi_err_slv: RTL and testbench



---
 rtl/ariane_soc_pkg.sv | 31 +++
 rtl/soc_err_rd_fifo.sv | 58 +++++
 rtl/soc_axi_err_slv.sv | 169 ++++++++++++++++
 tb/tb_soc_axi_err_slv.sv | 215 +++++++++++++++++++++
 4 files changed

// File: rtl/ariane_soc_pkg.sv
// ariane_soc: shared constants and types for the SoC default (error) slave.
//   RESP_DECERR    - AXI DECERR response code
//   IdWidthSlave   - AXI ID width on crossbar master ports (5 + clog2(4 slaves))
//   ERR_RESP_DATA  - default data pattern returned on every R beat
//   wr_state_e / rd_state_e - write / read FSM state encodings
//   sat_add32      - 32-bit saturating add of a 0..2 increment
package ariane_soc;

    localparam int unsigned IdWidthSlave  = 7;
    localparam logic [1:0]  RESP_DECERR   = 2'b11;
    localparam logic [63:0] ERR_RESP_DATA = 64'hDEAD_BEEF_DEAD_BEEF;

    typedef enum logic [1:0] {
        W_IDLE,
        W_DATA,
        W_RESP
    } wr_state_e;

    typedef enum logic {
        R_IDLE,
        R_BURST
    } rd_state_e;

    // Carry out of the 33-bit sum means the count would pass all-ones.
    function automatic logic [31:0] sat_add32(input logic [31:0] a, input logic [1:0] inc);
        logic [32:0] sum;
        sum = {1'b0, a} + {31'd0, inc};
        return sum[32] ? 32'hFFFF_FFFF : sum[31:0];
    endfunction

endpackage

// File: rtl/soc_err_rd_fifo.sv
// soc_err_rd_fifo: synchronous FIFO of outstanding read bursts {id, len}.
//   clk_i, rst_ni             - clock, async active-low reset
//   push_i, push_id_i/len_i   - enqueue (ignored when full)
//   pop_i                     - dequeue head (ignored when empty)
//   head_id_o, head_len_o     - current head entry
//   full_o, empty_o           - occupancy flags
//   one_left_o                - exactly one entry stored
// No bypass: a push is visible on the head the cycle after it is accepted.
module soc_err_rd_fifo #(
    parameter int unsigned IdWidth = 7,
    parameter int unsigned Depth   = 4
) (
    input  logic               clk_i,
    input  logic               rst_ni,
    input  logic               push_i,
    input  logic [IdWidth-1:0] push_id_i,
    input  logic [7:0]         push_len_i,
    input  logic               pop_i,
    output logic [IdWidth-1:0] head_id_o,
    output logic [7:0]         head_len_o,
    output logic               full_o,
    output logic               empty_o,
    output logic               one_left_o
);

    localparam int unsigned PtrW = $clog2(Depth);
    localparam int unsigned EntW = IdWidth + 8;

    logic [Depth-1:0][EntW-1:0] mem_q;
    // Pointers carry one extra wrap bit so full and empty are distinguishable.
    logic [PtrW:0] wr_ptr_q, rd_ptr_q, fill;
    logic          do_push, do_pop;

    assign fill       = wr_ptr_q - rd_ptr_q;
    assign full_o     = (fill == (PtrW+1)'(Depth));
    assign empty_o    = (fill == '0);
    assign one_left_o = (fill == (PtrW+1)'(1));
    assign do_push    = push_i & ~full_o;
    assign do_pop     = pop_i & ~empty_o;

    assign {head_id_o, head_len_o} = mem_q[rd_ptr_q[PtrW-1:0]];

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            if (do_push) wr_ptr_q <= wr_ptr_q + 1'b1;
            if (do_pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
        end
    end

    // Storage needs no reset: entries are only read between push and pop.
    always_ff @(posedge clk_i) begin
        if (do_push) mem_q[wr_ptr_q[PtrW-1:0]] <= {push_id_i, push_len_i};
    end

endmodule

// File: rtl/soc_axi_err_slv.sv
// soc_axi_err_slv: AXI4 terminating slave for the crossbar default port.
// Every transaction is answered with DECERR; read bursts return RespData.
//   clk_i, rst_ni            - clock, async active-low reset
//   aw_* / w_* / b_*         - write channels (AW id only, W data discarded)
//   ar_* / r_*               - read channels (AR id + len only)
//   err_cnt_o                - saturating count of AW + AR handshakes
// Read and write paths are independent; reads may queue up to MaxRdTxn bursts.
module soc_axi_err_slv
    import ariane_soc::*;
#(
    parameter int unsigned          IdWidth   = IdWidthSlave,
    parameter int unsigned          DataWidth = 64,
    parameter int unsigned          MaxRdTxn  = 4,
    parameter logic [DataWidth-1:0] RespData  = DataWidth'(ERR_RESP_DATA)
) (
    input  logic                 clk_i,
    input  logic                 rst_ni,
    input  logic                 aw_valid_i,
    output logic                 aw_ready_o,
    input  logic [IdWidth-1:0]   aw_id_i,
    input  logic                 w_valid_i,
    output logic                 w_ready_o,
    input  logic                 w_last_i,
    output logic                 b_valid_o,
    input  logic                 b_ready_i,
    output logic [IdWidth-1:0]   b_id_o,
    output logic [1:0]           b_resp_o,
    input  logic                 ar_valid_i,
    output logic                 ar_ready_o,
    input  logic [IdWidth-1:0]   ar_id_i,
    input  logic [7:0]           ar_len_i,
    output logic                 r_valid_o,
    input  logic                 r_ready_i,
    output logic [IdWidth-1:0]   r_id_o,
    output logic [DataWidth-1:0] r_data_o,
    output logic [1:0]           r_resp_o,
    output logic                 r_last_o,
    output logic [31:0]          err_cnt_o
);

    // ---------------- write path ----------------
    wr_state_e          wr_state_q, wr_state_d;
    logic [IdWidth-1:0] aw_id_q;
    logic               aw_hs;

    always_comb begin
        wr_state_d = wr_state_q;
        aw_ready_o = 1'b0;
        w_ready_o  = 1'b0;
        b_valid_o  = 1'b0;
        unique case (wr_state_q)
            W_IDLE: begin
                aw_ready_o = 1'b1;
                if (aw_valid_i) wr_state_d = W_DATA;
            end
            W_DATA: begin
                w_ready_o = 1'b1;
                if (w_valid_i && w_last_i) wr_state_d = W_RESP;
            end
            W_RESP: begin
                b_valid_o = 1'b1;
                if (b_ready_i) wr_state_d = W_IDLE;
            end
            default: wr_state_d = W_IDLE;
        endcase
    end

    assign aw_hs    = aw_valid_i & aw_ready_o;
    assign b_id_o   = aw_id_q;
    assign b_resp_o = RESP_DECERR;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wr_state_q <= W_IDLE;
            aw_id_q    <= '0;
        end else begin
            wr_state_q <= wr_state_d;
            if (aw_hs) aw_id_q <= aw_id_i;
        end
    end

    // ---------------- read path ----------------
    rd_state_e          rd_state_q, rd_state_d;
    logic [7:0]         beat_q, beat_d;
    logic               fifo_full, fifo_empty, fifo_one_left;
    logic [IdWidth-1:0] head_id;
    logic [7:0]         head_len;
    logic               ar_hs, r_hs, pop;

    assign ar_ready_o = ~fifo_full;
    assign ar_hs      = ar_valid_i & ar_ready_o;

    soc_err_rd_fifo #(
        .IdWidth (IdWidth),
        .Depth   (MaxRdTxn)
    ) i_rd_fifo (
        .clk_i      (clk_i),
        .rst_ni     (rst_ni),
        .push_i     (ar_hs),
        .push_id_i  (ar_id_i),
        .push_len_i (ar_len_i),
        .pop_i      (pop),
        .head_id_o  (head_id),
        .head_len_o (head_len),
        .full_o     (fifo_full),
        .empty_o    (fifo_empty),
        .one_left_o (fifo_one_left)
    );

    // Beats are counted up from 0 and compared to the head len, so len=255
    // ends at beat 255 without the 8-bit counter ever wrapping mid-burst.
    assign r_valid_o = (rd_state_q == R_BURST);
    assign r_last_o  = r_valid_o & (beat_q == head_len);
    assign r_id_o    = head_id;
    assign r_data_o  = RespData;
    assign r_resp_o  = RESP_DECERR;
    assign r_hs      = r_valid_o & r_ready_i;
    assign pop       = r_hs & r_last_o;

    always_comb begin
        rd_state_d = rd_state_q;
        beat_d     = beat_q;
        unique case (rd_state_q)
            R_IDLE: begin
                beat_d = '0;
                // Entering on the push itself gives first-beat-next-cycle latency.
                if (!fifo_empty || ar_hs) rd_state_d = R_BURST;
            end
            R_BURST: begin
                if (r_hs) begin
                    if (r_last_o) begin
                        beat_d = '0;
                        // Chain straight into the next burst when one is queued.
                        if (fifo_one_left && !ar_hs) rd_state_d = R_IDLE;
                    end else begin
                        beat_d = beat_q + 8'd1;
                    end
                end
            end
            default: rd_state_d = R_IDLE;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            rd_state_q <= R_IDLE;
            beat_q     <= '0;
        end else begin
            rd_state_q <= rd_state_d;
            beat_q     <= beat_d;
        end
    end

    // ---------------- error counter ----------------
    logic [31:0] err_cnt_q;
    logic [1:0]  cnt_inc;

    assign cnt_inc   = {1'b0, aw_hs} + {1'b0, ar_hs};
    assign err_cnt_o = err_cnt_q;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            err_cnt_q <= '0;
        end else if (cnt_inc != 2'd0) begin
            err_cnt_q <= sat_add32(err_cnt_q, cnt_inc);
        end
    end

endmodule

// File: tb/tb_soc_axi_err_slv.sv
module tb_soc_axi_err_slv;

    logic        clk_i = 1'b0;
    logic        rst_ni = 1'b0;
    logic        aw_valid_i = 1'b0, aw_ready_o;
    logic [6:0]  aw_id_i = '0;
    logic        w_valid_i = 1'b0, w_ready_o, w_last_i = 1'b0;
    logic        b_valid_o, b_ready_i = 1'b0;
    logic [6:0]  b_id_o;
    logic [1:0]  b_resp_o;
    logic        ar_valid_i = 1'b0, ar_ready_o;
    logic [6:0]  ar_id_i = '0;
    logic [7:0]  ar_len_i = '0;
    logic        r_valid_o, r_ready_i = 1'b0;
    logic [6:0]  r_id_o;
    logic [63:0] r_data_o;
    logic [1:0]  r_resp_o;
    logic        r_last_o;
    logic [31:0] err_cnt_o;

    int checks = 0;
    int failures = 0;

    always #5 clk_i = ~clk_i;

    soc_axi_err_slv dut (
        .clk_i(clk_i), .rst_ni(rst_ni),
        .aw_valid_i(aw_valid_i), .aw_ready_o(aw_ready_o), .aw_id_i(aw_id_i),
        .w_valid_i(w_valid_i), .w_ready_o(w_ready_o), .w_last_i(w_last_i),
        .b_valid_o(b_valid_o), .b_ready_i(b_ready_i), .b_id_o(b_id_o), .b_resp_o(b_resp_o),
        .ar_valid_i(ar_valid_i), .ar_ready_o(ar_ready_o), .ar_id_i(ar_id_i), .ar_len_i(ar_len_i),
        .r_valid_o(r_valid_o), .r_ready_i(r_ready_i), .r_id_o(r_id_o), .r_data_o(r_data_o),
        .r_resp_o(r_resp_o), .r_last_o(r_last_o), .err_cnt_o(err_cnt_o)
    );

    task automatic test_reset;
        rst_ni = 1'b0;
        repeat (2) @(negedge clk_i);
        checks++; if (aw_ready_o !== 1'b1) begin failures++; $display("FAIL rst_aw_ready got %b want 1", aw_ready_o); end
        checks++; if (ar_ready_o !== 1'b1) begin failures++; $display("FAIL rst_ar_ready got %b want 1", ar_ready_o); end
        checks++; if (w_ready_o !== 1'b0) begin failures++; $display("FAIL rst_w_ready got %b want 0", w_ready_o); end
        checks++; if (b_valid_o !== 1'b0) begin failures++; $display("FAIL rst_b_valid got %b want 0", b_valid_o); end
        checks++; if (r_valid_o !== 1'b0) begin failures++; $display("FAIL rst_r_valid got %b want 0", r_valid_o); end
        checks++; if (err_cnt_o !== 32'd0) begin failures++; $display("FAIL rst_err_cnt got %h want 0", err_cnt_o); end
        rst_ni = 1'b1;
        @(negedge clk_i);
    endtask

    task automatic test_write;
        aw_valid_i = 1'b1; aw_id_i = 7'h13;
        checks++; if (w_ready_o !== 1'b0) begin failures++; $display("FAIL wr_w_ready_before_aw got %b want 0", w_ready_o); end
        @(negedge clk_i);
        aw_valid_i = 1'b0; aw_id_i = '0;
        checks++; if (aw_ready_o !== 1'b0) begin failures++; $display("FAIL wr_aw_ready_data got %b want 0", aw_ready_o); end
        checks++; if (w_ready_o !== 1'b1) begin failures++; $display("FAIL wr_w_ready got %b want 1", w_ready_o); end
        for (int i = 0; i < 4; i++) begin
            w_valid_i = 1'b1; w_last_i = (i == 3);
            @(negedge clk_i);
            if (i < 3) begin
                checks++; if (b_valid_o !== 1'b0) begin failures++; $display("FAIL wr_b_early beat %0d got %b want 0", i, b_valid_o); end
            end
        end
        w_valid_i = 1'b0; w_last_i = 1'b0;
        checks++; if (b_valid_o !== 1'b1) begin failures++; $display("FAIL wr_b_valid got %b want 1", b_valid_o); end
        checks++; if (b_id_o !== 7'h13) begin failures++; $display("FAIL wr_b_id got %h want 13", b_id_o); end
        checks++; if (b_resp_o !== 2'b11) begin failures++; $display("FAIL wr_b_resp got %b want 11", b_resp_o); end
        checks++; if (err_cnt_o !== 32'd1) begin failures++; $display("FAIL wr_err_cnt got %h want 1", err_cnt_o); end
        @(negedge clk_i);
        checks++; if (b_valid_o !== 1'b1 || b_id_o !== 7'h13) begin failures++; $display("FAIL wr_b_hold got %b/%h want 1/13", b_valid_o, b_id_o); end
        b_ready_i = 1'b1;
        @(negedge clk_i);
        b_ready_i = 1'b0;
        checks++; if (b_valid_o !== 1'b0) begin failures++; $display("FAIL wr_b_done got %b want 0", b_valid_o); end
        checks++; if (aw_ready_o !== 1'b1) begin failures++; $display("FAIL wr_aw_ready_back got %b want 1", aw_ready_o); end
    endtask

    task automatic test_read;
        r_ready_i = 1'b1;
        ar_valid_i = 1'b1; ar_id_i = 7'h05; ar_len_i = 8'd3;
        checks++; if (r_valid_o !== 1'b0) begin failures++; $display("FAIL rd_r_valid_idle got %b want 0", r_valid_o); end
        @(negedge clk_i);
        ar_valid_i = 1'b0; ar_len_i = '0;
        for (int b = 0; b < 4; b++) begin
            checks++; if (r_valid_o !== 1'b1 || r_id_o !== 7'h05 || r_resp_o !== 2'b11 || r_data_o !== 64'hDEAD_BEEF_DEAD_BEEF)
                begin failures++; $display("FAIL rd_beat%0d got v=%b id=%h resp=%b data=%h want 1/05/11/deadbeefdeadbeef", b, r_valid_o, r_id_o, r_resp_o, r_data_o); end
            checks++; if (r_last_o !== (b == 3)) begin failures++; $display("FAIL rd_last beat %0d got %b want %b", b, r_last_o, (b == 3)); end
            @(negedge clk_i);
        end
        checks++; if (r_valid_o !== 1'b0) begin failures++; $display("FAIL rd_end got %b want 0", r_valid_o); end
        checks++; if (err_cnt_o !== 32'd2) begin failures++; $display("FAIL rd_err_cnt got %h want 2", err_cnt_o); end
        r_ready_i = 1'b0;
    endtask

    task automatic test_fifo_full;
        logic [6:0] exp_id;
        r_ready_i = 1'b0;
        for (int i = 0; i < 4; i++) begin
            ar_valid_i = 1'b1; ar_id_i = 7'h10 + 7'(i); ar_len_i = 8'd0;
            checks++; if (ar_ready_o !== 1'b1) begin failures++; $display("FAIL ff_ar_ready_%0d got %b want 1", i, ar_ready_o); end
            @(negedge clk_i);
        end
        ar_id_i = 7'h14;
        checks++; if (ar_ready_o !== 1'b0) begin failures++; $display("FAIL ff_full got %b want 0", ar_ready_o); end
        checks++; if (r_valid_o !== 1'b1 || r_id_o !== 7'h10) begin failures++; $display("FAIL ff_head got %b/%h want 1/10", r_valid_o, r_id_o); end
        @(negedge clk_i);
        checks++; if (ar_ready_o !== 1'b0 || r_id_o !== 7'h10 || r_last_o !== 1'b1) begin failures++; $display("FAIL ff_stall got rdy=%b id=%h last=%b want 0/10/1", ar_ready_o, r_id_o, r_last_o); end
        r_ready_i = 1'b1;
        @(negedge clk_i);
        checks++; if (ar_ready_o !== 1'b1) begin failures++; $display("FAIL ff_space got %b want 1", ar_ready_o); end
        for (int k = 1; k < 5; k++) begin
            exp_id = 7'h10 + 7'(k);
            checks++; if (r_valid_o !== 1'b1 || r_id_o !== exp_id) begin failures++; $display("FAIL ff_order k=%0d got %b/%h want 1/%h", k, r_valid_o, r_id_o, exp_id); end
            @(negedge clk_i);
            ar_valid_i = 1'b0;
        end
        checks++; if (r_valid_o !== 1'b0) begin failures++; $display("FAIL ff_drain got %b want 0", r_valid_o); end
        checks++; if (err_cnt_o !== 32'd7) begin failures++; $display("FAIL ff_err_cnt got %h want 7", err_cnt_o); end
        r_ready_i = 1'b0;
    endtask

    task automatic test_saturate;
        force dut.err_cnt_q = 32'hFFFF_FFFE;
        #1;
        release dut.err_cnt_q;
        aw_valid_i = 1'b1; aw_id_i = 7'h22;
        ar_valid_i = 1'b1; ar_id_i = 7'h33; ar_len_i = 8'd0;
        r_ready_i = 1'b1; b_ready_i = 1'b1;
        checks++; if (aw_ready_o !== 1'b1 || ar_ready_o !== 1'b1) begin failures++; $display("FAIL sat_ready got %b/%b want 1/1", aw_ready_o, ar_ready_o); end
        @(negedge clk_i);
        aw_valid_i = 1'b0; ar_valid_i = 1'b0;
        checks++; if (err_cnt_o !== 32'hFFFF_FFFF) begin failures++; $display("FAIL sat_both got %h want ffffffff", err_cnt_o); end
        checks++; if (r_valid_o !== 1'b1 || r_id_o !== 7'h33) begin failures++; $display("FAIL sat_r got %b/%h want 1/33", r_valid_o, r_id_o); end
        w_valid_i = 1'b1; w_last_i = 1'b1;
        @(negedge clk_i);
        w_valid_i = 1'b0; w_last_i = 1'b0;
        checks++; if (b_valid_o !== 1'b1 || b_id_o !== 7'h22) begin failures++; $display("FAIL sat_b got %b/%h want 1/22", b_valid_o, b_id_o); end
        @(negedge clk_i);
        aw_valid_i = 1'b1;
        @(negedge clk_i);
        aw_valid_i = 1'b0;
        checks++; if (err_cnt_o !== 32'hFFFF_FFFF) begin failures++; $display("FAIL sat_hold got %h want ffffffff", err_cnt_o); end
        w_valid_i = 1'b1; w_last_i = 1'b1;
        @(negedge clk_i);
        w_valid_i = 1'b0; w_last_i = 1'b0;
        @(negedge clk_i);
        b_ready_i = 1'b0; r_ready_i = 1'b0;
    endtask

    task automatic test_long_burst;
        int beats = 0, bad_last = 0, bad_hold = 0, bad_id = 0, cyc = 0;
        logic stalled = 1'b0;
        logic [6:0] s_id;
        logic s_last;
        logic [63:0] s_data;
        ar_valid_i = 1'b1; ar_id_i = 7'h2A; ar_len_i = 8'hFF; r_ready_i = 1'b0;
        @(negedge clk_i);
        ar_valid_i = 1'b0; ar_len_i = '0;
        while (beats < 256 && cyc < 3000) begin
            if (stalled && (r_valid_o !== 1'b1 || r_id_o !== s_id || r_last_o !== s_last || r_data_o !== s_data)) bad_hold++;
            if (r_valid_o === 1'b1 && r_id_o !== 7'h2A) bad_id++;
            r_ready_i = 1'($urandom_range(0, 1));
            stalled = 1'b0;
            if (r_valid_o === 1'b1 && r_ready_i) begin
                beats++;
                if (r_last_o !== (beats == 256)) bad_last++;
            end else if (r_valid_o === 1'b1) begin
                stalled = 1'b1; s_id = r_id_o; s_last = r_last_o; s_data = r_data_o;
            end
            @(negedge clk_i);
            cyc++;
        end
        r_ready_i = 1'b0;
        checks++; if (beats != 256) begin failures++; $display("FAIL long_beats got %0d want 256", beats); end
        checks++; if (bad_last != 0) begin failures++; $display("FAIL long_last got %0d bad want 0", bad_last); end
        checks++; if (bad_hold != 0) begin failures++; $display("FAIL long_hold got %0d unstable want 0", bad_hold); end
        checks++; if (bad_id != 0) begin failures++; $display("FAIL long_id got %0d bad want 0", bad_id); end
        checks++; if (r_valid_o !== 1'b0) begin failures++; $display("FAIL long_end got %b want 0", r_valid_o); end
    endtask

    task automatic test_reset_mid;
        aw_valid_i = 1'b1; aw_id_i = 7'h44;
        @(negedge clk_i);
        aw_valid_i = 1'b0; w_valid_i = 1'b1; w_last_i = 1'b1;
        @(negedge clk_i);
        w_valid_i = 1'b0; w_last_i = 1'b0;
        ar_valid_i = 1'b1; ar_id_i = 7'h07; ar_len_i = 8'd3; r_ready_i = 1'b1;
        @(negedge clk_i);
        ar_valid_i = 1'b0; ar_len_i = '0;
        @(negedge clk_i);
        checks++; if (r_valid_o !== 1'b1 || b_valid_o !== 1'b1) begin failures++; $display("FAIL mid_pre got r=%b b=%b want 1/1", r_valid_o, b_valid_o); end
        #2 rst_ni = 1'b0;
        #1;
        checks++; if (r_valid_o !== 1'b0 || b_valid_o !== 1'b0) begin failures++; $display("FAIL mid_async got r=%b b=%b want 0/0", r_valid_o, b_valid_o); end
        @(negedge clk_i);
        rst_ni = 1'b1;
        @(negedge clk_i);
        checks++; if (ar_ready_o !== 1'b1 || aw_ready_o !== 1'b1) begin failures++; $display("FAIL mid_ready got ar=%b aw=%b want 1/1", ar_ready_o, aw_ready_o); end
        checks++; if (err_cnt_o !== 32'd0) begin failures++; $display("FAIL mid_err_cnt got %h want 0", err_cnt_o); end
        checks++; if (r_valid_o !== 1'b0 || b_valid_o !== 1'b0) begin failures++; $display("FAIL mid_after got r=%b b=%b want 0/0", r_valid_o, b_valid_o); end
        r_ready_i = 1'b0;
    endtask

    initial begin
        test_reset();
        test_write();
        test_read();
        test_fifo_full();
        test_saturate();
        test_long_burst();
        test_reset_mid();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
